// File: rtl/readout_pkg.sv
// Shared definitions for the readout sequencer: FSM encoding, header byte, bytes-per-word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Optional build macro READOUT_HEADER_EN: prefixes every word with HEADER_BYTE on the
// UART stream. The per-word byte count below grows by one when it is defined.
package readout_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        POP       = 3'd2,
        WAIT_DATA = 3'd3,
        LOAD      = 3'd4,
        SEND      = 3'd5,
        WAIT_DONE = 3'd6
    } state_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

`ifdef READOUT_HEADER_EN
    localparam int HDR_BYTES = 1;
`else
    localparam int HDR_BYTES = 0;
`endif

    // Bytes emitted on the UART for one FIFO word, header included when enabled.
    function automatic int bytes_per_word(input int nb_word, input int nb_uart);
        return (nb_word / nb_uart) + HDR_BYTES;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Holds one captured FIFO word and presents it byte by byte, least-significant byte first.
// Latency: byte mux is combinational from the word register and byte index.
// Backpressure: index only moves on i_advance; the caller paces it with the UART handshake.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_capture      load i_word and rewind the byte index to 0
//   i_advance      step to the next byte (ignored on the last byte)
//   i_word         FIFO word to serialize
//   o_byte         byte currently selected
//   o_last         high while the selected byte is the final one of the word
// Build macro READOUT_HEADER_EN: index 0 selects HEADER_BYTE, data bytes follow.
module word_serializer
    import readout_pkg::*;
#(
    parameter int NB_WORD = 32,
    parameter int NB_UART = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_capture,
    input  logic               i_advance,
    input  logic [NB_WORD-1:0] i_word,
    output logic [NB_UART-1:0] o_byte,
    output logic               o_last
);

    localparam int NB_DATA  = NB_WORD / NB_UART;
    localparam int NB_BYTES = bytes_per_word(NB_WORD, NB_UART);
    localparam int NB_IDX   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;

    logic [NB_WORD-1:0] r_word;
    logic [NB_IDX-1:0]  r_idx;
    logic [NB_UART-1:0] w_byte;
    logic               w_last;

    assign w_last = (r_idx == NB_IDX'(NB_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_word <= '0;
            r_idx  <= '0;
        end else if (i_capture) begin
            r_word <= i_word;
            r_idx  <= '0;
        end else if (i_advance && !w_last) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    // Data byte k sits at index k+HDR_BYTES so the header, when present, owns index 0.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < NB_DATA; k++) begin
            if (r_idx == NB_IDX'(k + HDR_BYTES)) begin
                w_byte = r_word[k*NB_UART +: NB_UART];
            end
        end
`ifdef READOUT_HEADER_EN
        if (r_idx == '0) begin
            w_byte = NB_UART'(HEADER_BYTE);
        end
`endif
    end

    assign o_byte = w_byte;
    assign o_last = w_last;

endmodule

// File: rtl/readout_sequencer.sv
// Drains words from a FIFO and streams them to a UART transmitter, LSB byte first.
// Latency: start->pop 2 cycles; pop->first oTxDV RD_LATENCY+2 cycles; one word in flight max.
// Backpressure: waits in SEND while iTxActive, in WAIT_DONE until iTxDone, in CHECK while empty.
//
// Ports:
//   iClk, iRst            clock, synchronous active-high reset (highest priority)
//   iStart, iStop         session open / close pulses (close takes effect between words)
//   iFifoEmpty, iFifoData FIFO status and read data (valid RD_LATENCY cycles after oFifoRdEn)
//   oFifoRdEn             one-cycle FIFO pop strobe
//   iTxActive, iTxDone    UART busy level and byte-complete pulse
//   oTxDV, oTxByte        UART byte strobe and byte (held from oTxDV until iTxDone)
//   oBusy                 low only in IDLE
//   oWordCount            words fully sent this session, saturating
// Build macro READOUT_HEADER_EN: each word is preceded by HEADER_BYTE (see word_serializer).
module readout_sequencer
    import readout_pkg::*;
#(
    parameter int NB_WORD    = 32,
    parameter int NB_UART    = 8,
    parameter int RD_LATENCY = 1,
    parameter int NB_CNT     = 16
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iStart,
    input  logic               iStop,
    input  logic               iFifoEmpty,
    input  logic [NB_WORD-1:0] iFifoData,
    output logic               oFifoRdEn,
    input  logic               iTxActive,
    input  logic               iTxDone,
    output logic               oTxDV,
    output logic [NB_UART-1:0] oTxByte,
    output logic               oBusy,
    output logic [NB_CNT-1:0]  oWordCount
);

    state_t             r_state;
    state_t             w_next;
    logic               r_stop_pend;
    logic [1:0]         r_lat_cnt;
    logic [NB_UART-1:0] r_tx_byte;
    logic [NB_CNT-1:0]  r_word_count;

    logic               w_stop;
    logic               w_lat_done;
    logic               w_rd_en;
    logic               w_tx_dv;
    logic               w_capture;
    logic               w_advance;
    logic               w_word_done;
    logic               w_session_open;
    logic [NB_UART-1:0] w_ser_byte;
    logic               w_ser_last;

    // A stop arriving in the same cycle as CHECK is honoured immediately.
    assign w_stop     = r_stop_pend | iStop;
    assign w_lat_done = (r_lat_cnt == 2'(RD_LATENCY - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_rd_en        = 1'b0;
        w_tx_dv        = 1'b0;
        w_capture      = 1'b0;
        w_advance      = 1'b0;
        w_word_done    = 1'b0;
        w_session_open = 1'b0;
        case (r_state)
            IDLE: begin
                if (iStart && !iStop) begin
                    w_next         = CHECK;
                    w_session_open = 1'b1;
                end
            end
            CHECK: begin
                if (w_stop) begin
                    w_next = IDLE;
                end else if (!iFifoEmpty) begin
                    w_next = POP;
                end
            end
            POP: begin
                // Re-check empty here so a pop is never issued against an empty FIFO,
                // even if the flag changed since CHECK.
                if (!iFifoEmpty) begin
                    w_rd_en = 1'b1;
                    w_next  = WAIT_DATA;
                end else begin
                    w_next  = CHECK;
                end
            end
            WAIT_DATA: begin
                if (w_lat_done) begin
                    w_capture = 1'b1;
                    w_next    = LOAD;
                end
            end
            LOAD: begin
                w_next = SEND;
            end
            SEND: begin
                if (!iTxActive) begin
                    w_tx_dv = 1'b1;
                    w_next  = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (iTxDone) begin
                    if (w_ser_last) begin
                        w_word_done = 1'b1;
                        w_next      = CHECK;
                    end else begin
                        w_advance   = 1'b1;
                        w_next      = LOAD;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Stop request survives until the FSM is back in IDLE; stops seen in IDLE are dropped.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_stop_pend <= 1'b0;
        end else if (w_next == IDLE) begin
            r_stop_pend <= 1'b0;
        end else if (iStop && (r_state != IDLE)) begin
            r_stop_pend <= 1'b1;
        end
    end

    // Counts WAIT_DATA cycles; capture happens on the RD_LATENCY-th one.
    always_ff @(posedge iClk) begin
        if (iRst || (r_state != WAIT_DATA)) begin
            r_lat_cnt <= '0;
        end else if (!w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
        end
    end

    // Byte register only changes in LOAD, which keeps it stable across SEND/WAIT_DONE.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_tx_byte <= '0;
        end else if (r_state == LOAD) begin
            r_tx_byte <= w_ser_byte;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_word_count <= '0;
        end else if (w_session_open) begin
            r_word_count <= '0;
        end else if (w_word_done && (r_word_count != {NB_CNT{1'b1}})) begin
            r_word_count <= r_word_count + 1'b1;
        end
    end

    word_serializer #(
        .NB_WORD (NB_WORD),
        .NB_UART (NB_UART)
    ) u_word_serializer (
        .i_clk     (iClk),
        .i_rst     (iRst),
        .i_capture (w_capture),
        .i_advance (w_advance),
        .i_word    (iFifoData),
        .o_byte    (w_ser_byte),
        .o_last    (w_ser_last)
    );

    assign oFifoRdEn  = w_rd_en;
    assign oTxDV      = w_tx_dv;
    assign oTxByte    = r_tx_byte;
    assign oBusy      = (r_state != IDLE);
    assign oWordCount = r_word_count;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer: FIFO and UART models, hand-computed byte streams.
// Latency: n/a (testbench).
// Backpressure: UART model stays busy 10 cycles per byte on the main instance.
module tb_readout_sequencer;
    import readout_pkg::*;

    localparam int NBYTES = bytes_per_word(32, 8);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, stop;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data  = 32'h0;
    logic        rd_en, tx_dv, busy;
    logic        tx_active  = 1'b0;
    logic        tx_done    = 1'b0;
    logic [7:0]  tx_byte;
    logic [15:0] wc;

    int n_checks = 0;
    int n_err    = 0;

    readout_sequencer dut (
        .iClk       (clk),
        .iRst       (rst),
        .iStart     (start),
        .iStop      (stop),
        .iFifoEmpty (fifo_empty),
        .iFifoData  (fifo_data),
        .oFifoRdEn  (rd_en),
        .iTxActive  (tx_active),
        .iTxDone    (tx_done),
        .oTxDV      (tx_dv),
        .oTxByte    (tx_byte),
        .oBusy      (busy),
        .oWordCount (wc)
    );

    // FIFO model, read latency 1.
    logic        push_req = 1'b0;
    logic [31:0] push_word = 32'h0;
    logic [31:0] fq[$];
    int          rd_cnt = 0;
    int          rd_empty_err = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_cnt++;
            if (fifo_empty || fq.size() == 0) rd_empty_err++;
            else fifo_data <= fq.pop_front();
        end
        if (push_req) fq.push_back(push_word);
        fifo_empty <= (fq.size() == 0);
    end

    // UART model: 10 busy cycles per byte, then a one-cycle done pulse.
    logic [7:0] rx_q[$];
    logic [7:0] cur_byte = 8'h0;
    int         busy_cnt = 0;
    int         stab_err = 0;

    always @(posedge clk) begin
        tx_done <= 1'b0;
        if (rst) begin
            busy_cnt = 0;
            tx_active <= 1'b0;
        end else if (tx_dv) begin
            rx_q.push_back(tx_byte);
            cur_byte = tx_byte;
            busy_cnt = 10;
            tx_active <= 1'b1;
        end else if (busy_cnt > 0) begin
            if (tx_byte != cur_byte) stab_err++;
            busy_cnt--;
            if (busy_cnt == 0) begin
                tx_active <= 1'b0;
                tx_done   <= 1'b1;
            end
        end
    end

    // Second instance with RD_LATENCY=3: data valid only on the 3rd cycle after the pop.
    logic        start3 = 1'b0;
    logic        stop3  = 1'b0;
    logic        f3_avail = 1'b0;
    logic        f3_taken = 1'b0;
    logic        f3_empty;
    logic [31:0] f3_data = 32'hDEAD_BEEF;
    logic        rd3, tx_dv3, busy3;
    logic        tx_active3 = 1'b0;
    logic        tx_done3   = 1'b0;
    logic [7:0]  tx_byte3;
    logic [15:0] wc3;
    logic [7:0]  rx3[$];
    int          n3 = 0;
    int          rd3_cnt = 0;
    localparam logic [31:0] W3 = 32'h5A6B7C8D;

    assign f3_empty = !f3_avail || f3_taken;

    readout_sequencer #(.RD_LATENCY(3)) dut3 (
        .iClk       (clk),
        .iRst       (rst),
        .iStart     (start3),
        .iStop      (stop3),
        .iFifoEmpty (f3_empty),
        .iFifoData  (f3_data),
        .oFifoRdEn  (rd3),
        .iTxActive  (tx_active3),
        .iTxDone    (tx_done3),
        .oTxDV      (tx_dv3),
        .oTxByte    (tx_byte3),
        .oBusy      (busy3),
        .oWordCount (wc3)
    );

    always @(posedge clk) begin
        tx_done3 <= tx_dv3 && !rst;
        if (tx_dv3) rx3.push_back(tx_byte3);
        if (rd3) begin
            rd3_cnt++;
            f3_taken <= 1'b1;
            f3_data  <= 32'hDEAD_BEEF;
            n3 = 1;
        end else if (n3 == 2) begin
            f3_data <= W3;
            n3 = 3;
        end else if (n3 > 0) begin
            f3_data <= 32'hDEAD_BEEF;
            n3 = (n3 == 3) ? 0 : n3 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
        int j = i;
`ifdef READOUT_HEADER_EN
        if (i == 0) return HEADER_BYTE;
        j = i - 1;
`endif
        return w[j*8 +: 8];
    endfunction

    task automatic check_word(input string tag, input logic [31:0] w, input int base);
        for (int i = 0; i < NBYTES; i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (rx_q.size() > base + i) ? 32'(rx_q[base + i]) : 32'hFFFF_FFFF,
                32'(exp_byte(w, i)));
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        push_word = w;
        push_req  = 1'b1;
        @(negedge clk);
        push_req  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic wait_wc(input logic [15:0] n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wc == n) break;
        end
        chk(tag, 32'(wc), 32'(n));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rx_q.size() >= n) break;
        end
        chk(tag, 32'(rx_q.size() >= n), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int r0;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_rden",  32'(rd_en),   32'd0);
        chk("rst_txdv",  32'(tx_dv),   32'd0);
        chk("rst_txbyte",32'(tx_byte), 32'd0);
        chk("rst_wc",    32'(wc),      32'd0);
        chk("rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;

        // Single word, LSB first, then FSM parks in CHECK.
        push(32'hF1A8B3CC);
        base = rx_q.size();
        pulse_start();
        wait_wc(16'd1, 400, "t1_wc");
        repeat (5) @(negedge clk);
        check_word("t1_byte", 32'hF1A8B3CC, base);
        chk("t1_nbytes", 32'(rx_q.size() - base), 32'(NBYTES));
        chk("t1_state",  32'(dut.r_state), 32'(CHECK));
        chk("t1_busy",   32'(busy), 32'd1);
        // Start while busy must not clear the count.
        pulse_start();
        chk("t1_start_ignored", 32'(wc), 32'd1);
        pulse_stop();
        wait_idle(20, "t1_idle");
        chk("t1_state_idle", 32'(dut.r_state), 32'(IDLE));

        // Start and stop together in IDLE stay in IDLE.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 32'(busy), 32'd0);

        // Long empty period: no pops, then one word.
        r0 = rd_cnt;
        pulse_start();
        repeat (50) @(negedge clk);
        chk("t3_no_rd",  32'(rd_cnt - r0), 32'd0);
        chk("t3_state",  32'(dut.r_state), 32'(CHECK));
        base = rx_q.size();
        push(32'h44332211);
        wait_wc(16'd1, 400, "t3_wc");
        check_word("t3_byte", 32'h44332211, base);
        pulse_stop();
        wait_idle(40, "t3_idle");

        // Three words queued, stop during word 2: exactly two words go out.
        push(32'h03020100);
        push(32'h13121110);
        push(32'h23222120);
        base = rx_q.size();
        r0 = rd_cnt;
        pulse_start();
        wait_rx(base + NBYTES + 1, 600, "t2_word2_started");
        pulse_stop();
        wait_idle(600, "t2_idle");
        chk("t2_nbytes", 32'(rx_q.size() - base), 32'(2 * NBYTES));
        chk("t2_wc",     32'(wc), 32'd2);
        chk("t2_state",  32'(dut.r_state), 32'(IDLE));
        chk("t2_pops",   32'(rd_cnt - r0), 32'd2);
        check_word("t2_w1", 32'h03020100, base);
        check_word("t2_w2", 32'h13121110, base + NBYTES);

        // Reset mid-word after the second byte: everything clears, no more bytes.
        base = rx_q.size();
        pulse_start();
        wait_rx(base + 2, 600, "t4_two_bytes");
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy",   32'(busy),    32'd0);
        chk("t4_rden",   32'(rd_en),   32'd0);
        chk("t4_txdv",   32'(tx_dv),   32'd0);
        chk("t4_txbyte", 32'(tx_byte), 32'd0);
        chk("t4_wc",     32'(wc),      32'd0);
        chk("t4_state",  32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("t4_no_more_bytes", 32'(rx_q.size() - base), 32'd2);

        // Word 1: with the header build this is A5 01 00 00 00.
        base = rx_q.size();
        push(32'h00000001);
        pulse_start();
        wait_wc(16'd1, 400, "t5_wc");
        check_word("t5_byte", 32'h00000001, base);
        pulse_stop();
        wait_idle(40, "t5_idle");

        chk("stable_txbyte_errs", 32'(stab_err), 32'd0);
        chk("rd_while_empty",     32'(rd_empty_err), 32'd0);

        // RD_LATENCY=3 instance: only the 3rd-cycle data may be captured.
        f3_avail = 1'b1;
        @(negedge clk); start3 = 1'b1;
        @(negedge clk); start3 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wc3 == 16'd1) break;
        end
        chk("lat3_wc",     32'(wc3), 32'd1);
        chk("lat3_pops",   32'(rd3_cnt), 32'd1);
        chk("lat3_nbytes", 32'(rx3.size()), 32'(NBYTES));
        for (int i = 0; i < NBYTES; i++) begin
            chk($sformatf("lat3_byte[%0d]", i),
                (rx3.size() > i) ? 32'(rx3[i]) : 32'hFFFF_FFFF,
                32'(exp_byte(W3, i)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
